// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Purpose: bundles the requester-side burst handshake and the FIFO write-port
//          signals of the async-FIFO write arbiter into one port.
// Signals:
//   req        requester -> arb   per-requester burst request (level)
//   req_len    requester -> arb   per-requester burst length, slice i at [i*LEN_WIDTH +: LEN_WIDTH]
//   req_valid  requester -> arb   per-requester data word valid
//   req_data   requester -> arb   per-requester data word, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  arb -> requester   word accepted this cycle when ANDed with req_valid
//   gnt        arb -> requester   one-hot burst owner (registered)
//   full       fifo -> arb        write-side FIFO full flag
//   winc       arb -> fifo        write increment
//   wdata      arb -> fifo        write data, valid when winc=1
//   busy       arb -> observer    a burst is owned
//   burst_done arb -> observer    one-cycle pulse after the final word of a burst
// Modports: master = requesters + FIFO write-pointer side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic [NREQ-1:0]            req;
  logic [NREQ*LEN_WIDTH-1:0]  req_len;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            gnt;
  logic                       full;
  logic                       winc;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       busy;
  logic                       burst_done;

  modport master (
    output req, req_len, req_valid, req_data, full,
    input  req_ready, gnt, winc, wdata, busy, burst_done
  );

  modport slave (
    input  req, req_len, req_valid, req_data, full,
    output req_ready, gnt, winc, wdata, busy, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Purpose: round-robin arbiter that lets NREQ requesters share the write port
//          of an async FIFO in bursts. A requester with req=1 and a non-zero
//          req_len is granted the port, and exactly req_len words are then
//          written (stalling while full=1) before the port is re-arbitrated.
// Ports:
//   wclk    single clock, all logic on the rising edge
//   w_nrst  synchronous active-low reset
//   bus     fifo_wr_arbiter_if.slave (requests, data, FIFO write port, status)
// Parameters: NREQ (2..8), DATA_WIDTH, LEN_WIDTH (max burst 2^LEN_WIDTH-1).
module fifo_wr_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic               wclk,
  input  logic               w_nrst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_n;
  logic [NREQ-1:0]      gnt_q, gnt_n;
  logic [IDX_W-1:0]     gidx_q, gidx_n;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_n;
  logic                 done_q, done_n;

  logic [NREQ-1:0]      eligible;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic                 winc_c;
  logic [NREQ-1:0]      ready_c;

  // Zero-length requests are never eligible, so they can never be granted.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req[i] && (bus.req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
    end
  end

  // First eligible index found searching upward from rr_ptr, modulo NREQ
  // (NREQ need not be a power of two, hence the explicit modulo).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and output decode. Selecting in IDLE while burst_done is high
  // is allowed: the grant only becomes visible a cycle later, which gives the
  // single idle cycle between back-to-back bursts.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt_q;
    gidx_n   = gidx_q;
    cnt_n    = cnt_q;
    rr_ptr_n = rr_ptr;
    done_n   = 1'b0;
    winc_c   = 1'b0;
    ready_c  = '0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_n        = XFER;
          gnt_n          = '0;
          gnt_n[sel_idx] = 1'b1;
          gidx_n         = sel_idx;
          cnt_n          = bus.req_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      XFER: begin
        ready_c[gidx_q] = !bus.full;
        // The counter guard keeps the counter from ever wrapping below zero.
        winc_c = bus.req_valid[gidx_q] && !bus.full && (cnt_q != '0);
        if (winc_c) begin
          cnt_n = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_n  = IDLE;
            gnt_n    = '0;
            done_n   = 1'b1;
            rr_ptr_n = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!w_nrst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      cnt_q  <= '0;
      rr_ptr <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      gidx_q <= gidx_n;
      cnt_q  <= cnt_n;
      rr_ptr <= rr_ptr_n;
      done_q <= done_n;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.winc       = winc_c;
  // Forced to zero outside a burst so a non-owner's data never shows up here.
  assign bus.wdata      = (state == XFER) ? bus.req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH]
                                          : '0;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state == XFER);
  assign bus.burst_done = done_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Purpose: self-checking bench for fifo_wr_arbiter (NREQ=3 to exercise the
//          non-power-of-two round-robin wrap). A behavioural model tracks the
//          burst owner, words left and round-robin pointer and is compared
//          with the DUT on every falling edge; directed scenarios add literal
//          expectations, then randomized traffic (including resets) follows.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int LW   = 3;

  logic wclk;
  logic w_nrst;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .wclk   (wclk),
    .w_nrst (w_nrst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester word sequence numbers; a word is retired when the model says
  // it was written, so a duplicated or dropped word shows up as wrong wdata.
  int seq [NREQ];

  int   m_owner    = -1;
  int   m_left     = 0;
  int   m_ptr      = 0;
  logic m_done     = 1'b0;
  bit   seen_reset = 1'b0;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [DW-1:0] word_of(input int i, input int s);
    return DW'(i * 4096 + (s % 4096));
  endfunction

  function automatic logic [NREQ*LW-1:0] pack_len(input int l0, input int l1, input int l2);
    return {LW'(l2), LW'(l1), LW'(l0)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold until the next one.
  task automatic applyStimulus(input logic nrst, input logic [NREQ-1:0] r,
                               input logic [NREQ*LW-1:0] l, input logic [NREQ-1:0] v,
                               input logic f);
    @(posedge wclk);
    #1;
    w_nrst        = nrst;
    bus.req       = r;
    bus.req_len   = l;
    bus.req_valid = v;
    bus.full      = f;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = word_of(i, seq[i]);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, '0, '0, '0, 1'b0);
  endtask

  // Behavioural model: outputs this cycle follow from who owns the port, then
  // the model advances to what must hold after the coming rising edge.
  always @(negedge wclk) begin : model_p
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_rdy;
    logic            e_winc;
    logic [DW-1:0]   e_wdata;
    int              j;
    e_gnt   = '0;
    e_rdy   = '0;
    e_winc  = 1'b0;
    e_wdata = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_rdy[m_owner] = !bus.full;
      e_winc         = bus.req_valid[m_owner] && !bus.full;
      e_wdata        = bus.req_data[m_owner*DW +: DW];
    end
    if (seen_reset) begin
      checkOutput("gnt", 64'(bus.gnt), 64'(e_gnt));
      checkOutput("req_ready", 64'(bus.req_ready), 64'(e_rdy));
      checkOutput("winc", 64'(bus.winc), 64'(e_winc));
      checkOutput("busy", 64'(bus.busy), 64'(m_owner >= 0));
      checkOutput("burst_done", 64'(bus.burst_done), 64'(m_done));
      if (e_winc) checkOutput("wdata", 64'(bus.wdata), 64'(e_wdata));
    end
    if (e_winc) seq[m_owner]++;
    if (!w_nrst) begin
      m_owner    = -1;
      m_left     = 0;
      m_ptr      = 0;
      m_done     = 1'b0;
      seen_reset = 1'b1;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
    end else if (m_owner < 0) begin
      m_done = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (m_owner < 0 && bus.req[j] && bus.req_len[j*LW +: LW] != '0) begin
          m_owner = j;
          m_left  = int'(bus.req_len[j*LW +: LW]);
        end
      end
    end else begin
      m_done = 1'b0;
      if (e_winc) begin
        m_left--;
        if (m_left == 0) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
          m_done  = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int              ngr;
    logic [NREQ-1:0] grants [3];
    logic [NREQ-1:0] prev_gnt;
    int              nw;
    bit              done_seen;
    logic [DW-1:0]   words [$];
    logic [NREQ-1:0] r, v;
    logic [NREQ*LW-1:0] l;
    logic            f, n;

    w_nrst        = 1'b0;
    bus.req       = '0;
    bus.req_len   = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;

    // Reset state
    resetDut();
    @(negedge wclk);
    checkOutput("rst_gnt", 64'(bus.gnt), 64'h0);
    checkOutput("rst_busy", 64'(bus.busy), 64'h0);
    checkOutput("rst_winc", 64'(bus.winc), 64'h0);
    checkOutput("rst_done", 64'(bus.burst_done), 64'h0);
    checkOutput("rst_ready", 64'(bus.req_ready), 64'h0);

    // Single requester, len 3
    $display("[TB] single requester burst");
    applyStimulus(1'b1, 3'b001, pack_len(3, 0, 0), 3'b001, 1'b0);
    @(negedge wclk);
    checkOutput("t1_gnt_latency", 64'(bus.gnt), 64'h0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(3, 0, 0), 3'b001, 1'b0);
      @(negedge wclk);
      checkOutput("t1_gnt", 64'(bus.gnt), 64'h1);
      checkOutput("t1_winc", 64'(bus.winc), 64'h1);
      checkOutput("t1_wdata", 64'(bus.wdata), 64'(c - 1));
    end
    applyStimulus(1'b1, 3'b000, pack_len(3, 0, 0), 3'b001, 1'b0);
    @(negedge wclk);
    checkOutput("t1_done", 64'(bus.burst_done), 64'h1);
    checkOutput("t1_busy_after", 64'(bus.busy), 64'h0);
    checkOutput("t1_winc_after", 64'(bus.winc), 64'h0);
    applyStimulus(1'b1, 3'b000, pack_len(3, 0, 0), 3'b001, 1'b0);
    @(negedge wclk);
    checkOutput("t1_done_pulse", 64'(bus.burst_done), 64'h0);
    checkOutput("t1_gnt_idle", 64'(bus.gnt), 64'h0);

    // Contention between requesters 0 and 1
    $display("[TB] contention round-robin");
    resetDut();
    ngr      = 0;
    prev_gnt = '0;
    for (int i = 0; i < 3; i++) grants[i] = '0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 3'b011, pack_len(2, 2, 0), 3'b011, 1'b0);
      @(negedge wclk);
      if (bus.gnt !== '0 && prev_gnt === '0 && ngr < 3) begin
        grants[ngr] = bus.gnt;
        ngr++;
      end
      prev_gnt = bus.gnt;
      if (ngr == 3) break;
    end
    checkOutput("t2_num_grants", 64'(ngr), 64'd3);
    checkOutput("t2_first", 64'(grants[0]), 64'h1);
    checkOutput("t2_second", 64'(grants[1]), 64'h2);
    checkOutput("t2_third", 64'(grants[2]), 64'h1);
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 3'b000, pack_len(2, 2, 0), 3'b011, 1'b0);

    // Backpressure, requester 2, len 4
    $display("[TB] backpressure");
    resetDut();
    words.delete();
    applyStimulus(1'b1, 3'b100, pack_len(0, 0, 4), 3'b100, 1'b0);
    applyStimulus(1'b1, 3'b000, pack_len(0, 0, 4), 3'b100, 1'b0);
    @(negedge wclk);
    if (bus.winc === 1'b1) words.push_back(bus.wdata);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(0, 0, 4), 3'b100, 1'b1);
      @(negedge wclk);
      checkOutput("t3_stall_winc", 64'(bus.winc), 64'h0);
      checkOutput("t3_stall_ready", 64'(bus.req_ready), 64'h0);
      checkOutput("t3_stall_gnt", 64'(bus.gnt), 64'h4);
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(0, 0, 4), 3'b100, 1'b0);
      @(negedge wclk);
      if (bus.winc === 1'b1) words.push_back(bus.wdata);
    end
    checkOutput("t3_num_winc", 64'(words.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < words.size()) checkOutput("t3_word", 64'(words[i]), 64'(16'h2000 + i));
    end

    // Zero-length request is never granted
    $display("[TB] zero length");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 3'b010, pack_len(5, 0, 0), 3'b011, 1'b0);
      @(negedge wclk);
      checkOutput("t4_gnt", 64'(bus.gnt), 64'h0);
      checkOutput("t4_winc", 64'(bus.winc), 64'h0);
    end

    // Request dropped and length changed mid-burst
    $display("[TB] drop mid-burst");
    nw        = 0;
    done_seen = 1'b0;
    applyStimulus(1'b1, 3'b001, pack_len(5, 0, 0), 3'b001, 1'b0);
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(1, 0, 0), 3'b001, 1'b0);
      @(negedge wclk);
      if (bus.winc === 1'b1) nw++;
      if (bus.burst_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
    end
    checkOutput("t5_num_winc", 64'(nw), 64'd5);
    checkOutput("t5_done_seen", 64'(done_seen), 64'h1);

    // Reset mid-burst (rr_ptr is 1 here, so the later grant proves it cleared)
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 3'b010, pack_len(0, 5, 0), 3'b010, 1'b0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(0, 5, 0), 3'b010, 1'b0);
      @(negedge wclk);
      checkOutput("t6_winc_pre", 64'(bus.winc), 64'h1);
    end
    applyStimulus(1'b0, 3'b000, pack_len(0, 5, 0), 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 3'b000, pack_len(0, 5, 0), 3'b010, 1'b0);
      @(negedge wclk);
      checkOutput("t6_gnt_post", 64'(bus.gnt), 64'h0);
      checkOutput("t6_winc_post", 64'(bus.winc), 64'h0);
    end
    applyStimulus(1'b1, 3'b011, pack_len(2, 2, 0), 3'b000, 1'b0);
    applyStimulus(1'b1, 3'b000, pack_len(2, 2, 0), 3'b000, 1'b0);
    @(negedge wclk);
    checkOutput("t6_rr_reset", 64'(bus.gnt), 64'h1);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 3'b000, pack_len(2, 2, 0), 3'b011, 1'b0);

    // Randomized traffic, the model checks every cycle
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      r = NREQ'($urandom);
      l = (NREQ*LW)'($urandom);
      for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 4) == 0);
      n = ($urandom_range(0, 299) != 0);
      applyStimulus(n, r, l, v, f);
    end
    applyStimulus(1'b1, '0, '0, '0, 1'b0);
    @(negedge wclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing the async FIFO write port (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, FIFO word width.
REQ-003 Parameter LEN_WIDTH, default 4, burst-length field width; maximum burst is 2^LEN_WIDTH-1 words.
REQ-004 wclk  in  1  single clock; all logic on rising edge.
REQ-005 w_nrst  in  1  reset, synchronous, active-low.
REQ-006 req  in  NREQ  per-requester burst request, level.
REQ-007 req_len  in  NREQ*LEN_WIDTH  per-requester burst length in words; slice i at [i*LEN_WIDTH +: LEN_WIDTH].
REQ-008 req_valid  in  NREQ  per-requester data word valid.
REQ-009 req_data  in  NREQ*DATA_WIDTH  per-requester data word; slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  out  NREQ  per-requester word accepted this cycle when ANDed with req_valid.
REQ-011 gnt  out  NREQ  one-hot current burst owner, registered.
REQ-012 full  in  1  write-side FIFO full flag from the write-pointer block.
REQ-013 winc  out  1  FIFO write increment to the write-pointer block.
REQ-014 wdata  out  DATA_WIDTH  FIFO write data, valid when winc=1.
REQ-015 busy  out  1  high while a burst is owned (state XFER).
REQ-016 burst_done  out  1  one-cycle pulse, registered, after the final word of a burst.

Function
REQ-017 The FSM SHALL have two states, IDLE and XFER.
REQ-018 A requester SHALL be eligible only when req[i]=1 and req_len[i]!=0; zero-length requests are ignored and never granted.
REQ-019 In IDLE with at least one eligible requester, the block SHALL select one by round-robin starting at priority pointer rr_ptr, searching upward modulo NREQ.
REQ-020 Selection SHALL register gnt (one-hot), latch req_len of the winner into a word counter, and move to XFER on the next edge; grant latency is one cycle from req to gnt.
REQ-021 In IDLE, gnt, req_ready, winc and busy SHALL be 0.
REQ-022 In XFER, req_ready[g] SHALL equal !full for the granted index g; all other req_ready bits SHALL be 0.
REQ-023 winc SHALL equal req_valid[g] & !full in XFER (combinational), and wdata SHALL equal req_data slice g.
REQ-024 Each winc SHALL decrement the word counter by 1; no other event changes it.
REQ-025 When winc=1 and counter=1, the block SHALL return to IDLE next edge, clear gnt, pulse burst_done for the following cycle, and set rr_ptr to (g+1) mod NREQ.
REQ-026 full=1 SHALL stall the burst with winc=0 indefinitely; there is no timeout.
REQ-027 Deassertion of req[g] or change of req_len[g] during XFER SHALL be ignored; the burst completes its latched length.
REQ-028 Non-granted requesters SHALL see req_ready=0 and their data SHALL never reach wdata.
REQ-029 A new grant SHALL NOT be issued in the same cycle burst_done is asserted; the earliest next gnt is one cycle after returning to IDLE (one idle cycle between bursts).
REQ-030 Counter SHALL be LEN_WIDTH bits and never wrap; winc is never asserted with counter=0.

Reset
REQ-031 On wclk edge with w_nrst=0: state=IDLE, gnt=0, counter=0, rr_ptr=0, burst_done=0; winc, req_ready and busy SHALL therefore be 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no further winc; words already written remain in the FIFO.

Verification
REQ-033 Single requester: req[0]=1, len=3, valid held, full=0 -> gnt=01 one cycle later, 3 consecutive winc with req_data[0] words, burst_done one cycle after the third winc, busy low after.
REQ-034 Contention: req=11 both len=2 from reset -> requester 0 granted first, then requester 1; third burst goes to 0 again (rr_ptr alternates).
REQ-035 Backpressure: full=1 for 4 cycles mid-burst of len=4 -> winc=0 and req_ready=0 those cycles; exactly 4 total winc; no duplicated or dropped words.
REQ-036 Zero length: req[1]=1 with len=0, req[0]=0 -> gnt stays 0, winc never asserts.
REQ-037 Drop and reset: req[0] deasserted after 1 of 5 words -> remaining 4 words still written; separate run asserting w_nrst=0 after 2 words -> next cycle IDLE, gnt=0, rr_ptr=0, no further winc.
